// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers x/y from incoming VGA syncs, checks 800x525 geometry and locks onto the stream.
// Define VGA_SYNC_RX_ERRCNT_EN to add the err_count / last_err diagnostic outputs.
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic        pix_valid,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        frame_start,
  output logic        locked,
  output logic        err
`ifdef VGA_SYNC_RX_ERRCNT_EN
  ,
  output logic [15:0] err_count,
  output logic [2:0]  last_err
`endif
);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS1 = 10'(H_SYNC - 1);
  localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] VSW = 10'(V_SYNC);
  localparam logic [9:0] HA0 = 10'(H_ACT_START);
  localparam logic [9:0] HA1 = 10'(H_ACT_START + H_ACT - 1);
  localparam logic [9:0] VA0 = 10'(V_ACT_START);
  localparam logic [9:0] VA1 = 10'(V_ACT_START + V_ACT - 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] LF = GW'(LOCK_FRAMES);
  state_t state, state_nxt;
  logic [GW-1:0] good, good_nxt;
  logic dirty, dirty_nxt, clean;
  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt, v_inc;
  logic hs_prev, vs_line;
  logic hs_fall, hs_rise, fs, chk, active;
  logic e_line, e_hsw, e_frame, e_vsw, e_sat, any_err;
  // Indices below are the ones this sample is assigned (HS fall sample is h=0).
  always_comb begin
    hs_fall = hs_prev & ~hs_in;
    hs_rise = ~hs_prev & hs_in;
    fs      = hs_fall & vs_line & ~vs_in;
    h_nxt   = hs_fall ? 10'd0 : h_cnt + {9'd0, h_cnt != 10'h3ff};
    v_inc   = v_cnt + {9'd0, v_cnt != 10'h3ff};
    v_nxt   = !hs_fall ? v_cnt : fs ? 10'd0 : v_inc;
    chk     = pix_en & (state != SEARCH);
    e_line  = chk & hs_fall & (h_cnt != HT1);
    e_hsw   = chk & hs_rise & (h_cnt != HS1);
    e_frame = chk & fs & (v_cnt != VT1);
    e_vsw   = chk & hs_fall & ~vs_line & vs_in & (v_inc != VSW);
    e_sat   = chk & (hs_fall ? ~fs & (v_cnt == 10'h3fe) : (h_cnt == 10'h3fe));
    any_err = e_line | e_hsw | e_frame | e_vsw | e_sat;
    active  = (h_nxt >= HA0) && (h_nxt <= HA1) && (v_nxt >= VA0) && (v_nxt <= VA1);
  end
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    dirty_nxt = pix_en ? (fs ? 1'b0 : dirty | any_err) : dirty;
    clean     = ~dirty & ~any_err;
    if (pix_en)
      case (state)
        SEARCH: if (fs) begin
          state_nxt = TRACK;
          good_nxt  = '0;
        end
        TRACK: if (fs) begin
          good_nxt  = clean ? good + 1'b1 : '0;
          state_nxt = (clean && (good + 1'b1 == LF)) ? LOCKED : TRACK;
        end
        LOCKED: if (any_err) begin
          state_nxt = TRACK;
          good_nxt  = '0;
        end
        default: state_nxt = SEARCH;
      endcase
  end
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      state <= SEARCH;
      good  <= '0;
      dirty <= 1'b0;
    end else begin
      state <= state_nxt;
      good  <= good_nxt;
      dirty <= dirty_nxt;
    end
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs_prev     <= 1'b1;
      vs_line     <= 1'b1;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
    end else begin
      pix_valid   <= pix_en & active & (state == LOCKED);
      frame_start <= pix_en & fs;
      err         <= any_err;
      if (pix_en) begin
        h_cnt   <= h_nxt;
        v_cnt   <= v_nxt;
        hs_prev <= hs_in;
        if (hs_fall) vs_line <= vs_in;
        x_out <= h_nxt - HA0;
        y_out <= v_nxt - VA0;
        r_out <= r_in;
        g_out <= g_in;
        b_out <= b_in;
      end
    end
  assign locked = (state == LOCKED);
`ifdef VGA_SYNC_RX_ERRCNT_EN
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      err_count <= '0;
      last_err  <= '0;
    end else if (any_err) begin
      err_count <= err_count + {15'd0, ~&err_count};
      last_err  <= e_line ? 3'd1 : e_hsw ? 3'd2 : e_frame ? 3'd3 : e_vsw ? 3'd4 : 3'd5;
    end
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: randomized line/frame stream with injected geometry faults; expected
// events are queued by a frame-level model and popped by a monitor on each DUT event.
module tb_vga_sync_rx;
  localparam int H_TOTAL = 32, H_SYNC = 4, HAS = 8, HA = 20;
  localparam int V_TOTAL = 16, V_SYNC = 2, VAS = 4, VA = 10, LOCK_FRAMES = 2;

  logic CLOCK_50 = 1'b0, reset, pix_en, hs_in, vs_in;
  logic [7:0] r_in, g_in, b_in, r_out, g_out, b_out;
  logic pix_valid, frame_start, locked, err;
  logic [9:0] x_out, y_out;
`ifdef VGA_SYNC_RX_ERRCNT_EN
  logic [15:0] err_count;
  logic [2:0] last_err;
`endif

  vga_sync_rx #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_ACT_START(HAS), .H_ACT(HA),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_ACT_START(VAS), .V_ACT(VA),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pix_en(pix_en), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .pix_valid(pix_valid), .x_out(x_out),
    .y_out(y_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .frame_start(frame_start), .locked(locked), .err(err)
`ifdef VGA_SYNC_RX_ERRCNT_EN
    , .err_count(err_count), .last_err(last_err)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    bit pv, fs, er, lk;
    logic [9:0] x, y;
    logic [7:0] r, g, b;
    logic [2:0] code;
    logic [15:0] cnt;
  } ev_t;

  ev_t q[$];
  ev_t m_e;
  int checks = 0, failures = 0, gap = 2;
  bit rnd_gap = 0;
  // Stream-level model state: derived from the line/frame descriptors the generator emits.
  bit started = 0, locked_m = 0, frame_err = 0, vs_last = 1;
  int clean_run = 0, prev_len = H_TOTAL, prev_lines = V_TOTAL, err_cnt_m = 0;

  task automatic put(input int k, input int v, input int hl, input bit vs);
    ev_t ev;
    bit fall, rise, fs, e1, e2, e3, e4, e5, was;
    int h;
    fall = (k == 0);
    rise = (k == hl);
    fs = fall && vs_last && !vs;
    e1 = started && fall && prev_len != H_TOTAL;
    e2 = started && rise && hl != H_SYNC;
    e3 = started && fs && prev_lines != V_TOTAL;
    e4 = started && fall && !vs_last && vs && v != V_SYNC;
    e5 = started && k == 1023;
    h = (k > 1023) ? 1023 : k;
    ev.er = e1 | e2 | e3 | e4 | e5;
    ev.code = e1 ? 3'd1 : e2 ? 3'd2 : e3 ? 3'd3 : e4 ? 3'd4 : 3'd5;
    ev.fs = fs;
    ev.r = 8'($urandom);
    ev.g = 8'($urandom);
    ev.b = 8'($urandom);
    ev.x = 10'(h - HAS);
    ev.y = 10'(v - VAS);
    was = locked_m;
    ev.pv = was && h >= HAS && h < HAS + HA && v >= VAS && v < VAS + VA;
    if (ev.er && was) begin
      locked_m = 0;
      clean_run = 0;
      frame_err = !fs;
    end else if (fs) begin
      if (started) begin
        clean_run = (frame_err || ev.er) ? 0 : clean_run + 1;
        if (clean_run >= LOCK_FRAMES) locked_m = 1;
      end
      started = 1;
      frame_err = 0;
    end else if (ev.er) frame_err = 1;
    if (ev.er && err_cnt_m < 65535) err_cnt_m++;
    ev.cnt = 16'(err_cnt_m);
    ev.lk = locked_m;
    @(negedge CLOCK_50);
    pix_en = 1;
    hs_in = (k >= hl);
    vs_in = vs;
    r_in = ev.r;
    g_in = ev.g;
    b_in = ev.b;
    if (ev.pv || ev.fs || ev.er) q.push_back(ev);
    gap = rnd_gap ? int'($urandom_range(3, 1)) : 2;
    repeat (gap - 1) begin
      @(negedge CLOCK_50);
      pix_en = 0;
    end
  endtask

  task automatic send_line(input int v, input int k0, input int len, input int hl, input bit vs);
    for (int k = k0; k < len; k++) put(k, v, hl, vs);
    prev_len = len;
    vs_last = vs;
  endtask

  // kind: 0 ideal, 1 short line, 2 narrow HS, 3 short frame, 4 wide VS, 5 runaway line
  task automatic send_frame(input int kind);
    int nl, bad, len, hl;
    nl = (kind == 3) ? V_TOTAL - 1 : V_TOTAL;
    bad = int'($urandom_range(nl - 2, V_SYNC + 1));
    for (int v = 0; v < nl; v++) begin
      len = (kind == 1 && v == bad) ? H_TOTAL - 1 : (kind == 5 && v == bad) ? 1100 : H_TOTAL;
      hl = (kind == 2 && v == bad) ? H_SYNC - 1 : H_SYNC;
      send_line(v, 0, len, hl, v >= ((kind == 4) ? V_SYNC + 1 : V_SYNC));
    end
    prev_lines = nl;
  endtask

  always @(negedge CLOCK_50) begin
    if (pix_valid || frame_start || err) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got pv=%0b fs=%0b err=%0b lk=%0b required none", pix_valid, frame_start, err, locked);
      end else begin
        m_e = q.pop_front();
        if (pix_valid !== m_e.pv || frame_start !== m_e.fs || err !== m_e.er || locked !== m_e.lk ||
            (m_e.pv && {x_out, y_out, r_out, g_out, b_out} !== {m_e.x, m_e.y, m_e.r, m_e.g, m_e.b})) begin
          failures++;
          $display("FAIL event pv/fs/err/lk got %b%b%b%b required %b%b%b%b x,y got %0d,%0d required %0d,%0d rgb got %h%h%h required %h%h%h",
                   pix_valid, frame_start, err, locked, m_e.pv, m_e.fs, m_e.er, m_e.lk, x_out, y_out,
                   m_e.x, m_e.y, r_out, g_out, b_out, m_e.r, m_e.g, m_e.b);
        end
`ifdef VGA_SYNC_RX_ERRCNT_EN
        if (m_e.er) begin
          checks++;
          if (last_err !== m_e.code || err_count !== m_e.cnt) begin
            failures++;
            $display("FAIL err_diag last_err/err_count got %0d/%0d required %0d/%0d", last_err, err_count, m_e.code, m_e.cnt);
          end
        end
`endif
      end
    end
  end

  task automatic check_zero(input string name);
    logic [52:0] all;
    all = {pix_valid, x_out, y_out, r_out, g_out, b_out, frame_start, locked, err};
`ifdef VGA_SYNC_RX_ERRCNT_EN
    all = all | 53'({err_count, last_err});
`endif
    checks++;
    if (all !== '0) begin
      failures++;
      $display("FAIL %s outputs got %h required 0", name, all);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 0; pix_en = 0; hs_in = 1; vs_in = 1; r_in = 0; g_in = 0; b_in = 0;
    repeat (3) @(negedge CLOCK_50);
    check_zero("reset_state");
    reset = 1;
    repeat (4) send_frame(0);
    rnd_gap = 1;
    for (int a = 1; a <= 5; a++) begin
      send_frame(a);
      repeat (3) send_frame(0);
    end
    for (int v = 0; v < VAS + 2; v++) send_line(v, 0, H_TOTAL, H_SYNC, v >= V_SYNC);
    send_line(VAS + 2, 0, HAS + 6, H_SYNC, 1);
    @(negedge CLOCK_50);
    pix_en = 0;
    @(posedge CLOCK_50);
    #2;
    checks++;
    if (locked !== locked_m || locked_m != 1 || q.size() != 0) begin
      failures++;
      $display("FAIL pre_reset locked got %0b required 1 pending got %0d required 0", locked, q.size());
    end
    reset = 0;
    #1;
    check_zero("async_reset");
    repeat (3) @(negedge CLOCK_50);
    reset = 1;
    started = 0; locked_m = 0; clean_run = 0; frame_err = 0; vs_last = 1;
    err_cnt_m = 0;
    send_line(VAS + 2, HAS + 6, H_TOTAL, H_SYNC, 1);
    for (int v = VAS + 3; v < V_TOTAL; v++) send_line(v, 0, H_TOTAL, H_SYNC, 1);
    repeat (4) send_frame(0);
    repeat (4) begin
      @(negedge CLOCK_50);
      pix_en = 0;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_events pending got %0d required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Receive-side counterpart to the VGA timing generator. Samples an incoming 640x480@60 stream (HS, VS, 24-bit RGB) on a per-pixel strobe, recovers pixel coordinates from the sync edges, and checks line and frame geometry against the 800x525 timing. It acquires lock through a small state machine and emits registered active-area pixels with x/y for downstream capture (frame grabber, loopback self-test).

## Interface
Parameters:
- H_TOTAL, 800, pixels per line
- H_SYNC, 96, HS low width in pixels
- H_ACT_START, 144, first active pixel index
- H_ACT, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, VS low width in lines
- V_ACT_START, 35, first active line index
- V_ACT, 480, active lines
- LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
- CLOCK_50  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  one-cycle strobe per pixel; all inputs below are sampled only when high
- hs_in, vs_in  in  1  active-low syncs
- r_in, g_in, b_in  in  8 each  pixel data
- pix_valid  out  1  registered pixel is in the active area and the block is LOCKED
- x_out  out  10  active x, 0..639
- y_out  out  10  active y, 0..479
- r_out, g_out, b_out  out  8 each  registered pixel data
- frame_start  out  1  one-cycle pulse at each VS falling edge
- locked  out  1  FSM in LOCKED
- err  out  1  one-cycle pulse on any geometry violation

## Operation
- Only pix_en cycles count as samples. hs_prev and vs_prev hold the previous sample. h_cnt and v_cnt are 10-bit.
- HS falling edge (hs_prev=1, hs_in=0):
  - h_cnt <= 0.
  - Error if old h_cnt != H_TOTAL-1, unless the FSM is in SEARCH.
  - Line-level VS handling happens at this same sample.
- Other samples: h_cnt <= h_cnt+1, saturating at 1023. Reaching 1023 raises err once.
- HS rising edge: error if h_cnt != H_SYNC-1.
- Line-level VS, evaluated only at HS falling edges; vs_line holds vs_in from the previous HS fall:
  - vs_line=1, vs_in=0: frame start. v_cnt <= 0, pulse frame_start. Error if old v_cnt != V_TOTAL-1 (not in SEARCH).
  - vs_line=0, vs_in=1: error if new v_cnt != V_SYNC.
  - Otherwise v_cnt <= v_cnt+1, saturating at 1023 with err.
  - VS changing between HS falls is ignored.
- Active area (decided on the sample's indices):
  - Condition: H_ACT_START <= h <= H_ACT_START+H_ACT-1 and V_ACT_START <= v <= V_ACT_START+V_ACT-1.
  - x_out = h-H_ACT_START, y_out = v-V_ACT_START, 10-bit unsigned.
- Lock FSM:
  - SEARCH: wait for the first frame start, then go to TRACK with good=0.
  - TRACK: an error in the frame clears good. At each frame start, if the frame was clean, good++. Go to LOCKED when good reaches LOCK_FRAMES; that frame start is the transition point.
  - LOCKED: any err goes to TRACK with good=0.
- Simultaneous errors in one sample produce a single err pulse.

## Timing
- Outputs are registered. Data for the sample taken at pix_en in cycle N appears in cycle N+1.
- pix_valid, frame_start and err are high for exactly one CLOCK_50 cycle per sample. The data outputs hold their value between strobes.
- Reset values (asynchronous, immediate):
  - FSM=SEARCH, h_cnt=v_cnt=0, hs_prev=vs_prev=vs_line=1.
  - All outputs 0.
- Deasserting reset mid-frame re-enters SEARCH. No err is raised before the first frame start.
- locked rises one cycle after the frame-start sample that completes LOCK_FRAMES clean frames. It falls one cycle after the erroring sample.
- pix_en may be continuous or spaced. The block is insensitive to the gap between strobes.

## Configuration
- VGA_SYNC_RX_ERRCNT_EN defined:
  - Adds output err_count (16 bits): a saturating count of err pulses, reset to 0.
  - Adds output last_err (3 bits): code of the most recent error. 1=line length, 2=HS width, 3=frame length, 4=VS width, 5=counter saturation.
  - When several errors fire in one sample, the lowest code wins.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

## Test plan
- Drive 3 ideal frames from the generator timing (pix_en every 2nd cycle):
  - frame_start pulses 3 times.
  - locked rises after the 3rd frame start.
  - No err.
  - In the 4th frame, the pixel at h=144, v=35 yields pix_valid with x=0, y=0.
  - Last active pixel yields x=639, y=479.
- After lock, shorten one line to 799 pixels: err pulses once at the next HS fall, locked drops, and re-lock occurs after 2 clean frames.
- HS low for 95 pixels on one line: err at the HS rising edge. With VGA_SYNC_RX_ERRCNT_EN defined, last_err=2 and err_count=1.
- Frame of 524 lines: err at the frame start, and v_cnt restarts at 0.
- Hold HS high for more than 1024 samples: h_cnt saturates at 1023 and err pulses exactly once.
- Assert reset mid-line while LOCKED: all outputs are 0 immediately. On release, no err before the first frame start.
